// File: rtl/fp_result_fifo.sv
// Elastic in-order result buffer behind the pipelined formula block, with valid/ready on both sides.
// Optional pop statistics (total and Inf/NaN count) are compiled in by defining FP_RESULT_FIFO_STATS_EN.
module fp_result_fifo #(
    parameter int FLEN  = 64,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       up_vld,
    output logic                       up_rdy,
    input  logic [FLEN-1:0]            up_data,
    output logic                       dn_vld,
    input  logic                       dn_rdy,
    output logic [FLEN-1:0]            dn_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [31:0]                stat_total,
    output logic [31:0]                stat_special
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [FLEN-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    // Handshake flags depend only on the registered occupancy, never on the peer's signals.
    assign up_rdy  = (count != FULL);
    assign dn_vld  = (count != '0);
    assign dn_data = mem[rd_ptr];
    assign push    = up_vld && up_rdy;
    assign pop     = dn_vld && dn_rdy;

    // NOTE: storage carries no reset; occupancy gates every read, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= up_data;
        end
    end

    // NOTE: non-blocking assignments keep every register reading pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FP_RESULT_FIFO_STATS_EN
    localparam int EXP_HI = (FLEN == 32) ? 30 : 62;
    localparam int EXP_LO = (FLEN == 32) ? 23 : 52;

    logic exp_all_ones;

    // Plain bit-field reduction: Inf and every NaN share an all-ones exponent.
    assign exp_all_ones = &dn_data[EXP_HI:EXP_LO];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_total   <= '0;
            stat_special <= '0;
        end else if (pop) begin
            stat_total <= stat_total + 32'd1;
            if (exp_all_ones) begin
                stat_special <= stat_special + 32'd1;
            end
        end
    end
`else
    assign stat_total   = '0;
    assign stat_special = '0;
`endif

endmodule

// File: tb/tb_fp_result_fifo.sv
// Self-checking bench for fp_result_fifo: directed phases plus randomized traffic checked against
// a queue-based reference model of the buffer contents and the pop statistics.
module tb_fp_result_fifo;

    localparam int FLEN  = 64;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            up_vld;
    logic            up_rdy;
    logic [FLEN-1:0] up_data;
    logic            dn_vld;
    logic            dn_rdy;
    logic [FLEN-1:0] dn_data;
    logic [CW-1:0]   count;
    logic [31:0]     stat_total;
    logic [31:0]     stat_special;

    fp_result_fifo #(.FLEN(FLEN), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .up_vld       (up_vld),
        .up_rdy       (up_rdy),
        .up_data      (up_data),
        .dn_vld       (dn_vld),
        .dn_rdy       (dn_rdy),
        .dn_data      (dn_data),
        .count        (count),
        .stat_total   (stat_total),
        .stat_special (stat_special)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [63:0] out_q[$];
    int          pushes = 0;
    int          pops   = 0;
    int unsigned tot_m  = 0;
    int unsigned spec_m = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_special(input logic [63:0] v);
        return ((v >> 52) & 64'h7FF) == 64'h7FF;
    endfunction

    function automatic logic [63:0] rand_val();
        logic [63:0] v;
        v = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) v[62:52] = 11'h7FF;
        return v;
    endfunction

    task automatic check_state();
        check("up_rdy", 64'(up_rdy), 64'(exp_q.size() != DEPTH));
        check("dn_vld", 64'(dn_vld), 64'(exp_q.size() != 0));
        check("count", 64'(count), 64'(exp_q.size()));
        if (exp_q.size() != 0) check("dn_data", dn_data, exp_q[0]);
`ifdef FP_RESULT_FIFO_STATS_EN
        check("stat_total", 64'(stat_total), 64'(tot_m));
        check("stat_special", 64'(stat_special), 64'(spec_m));
`else
        check("stat_total", 64'(stat_total), 64'd0);
        check("stat_special", 64'(stat_special), 64'd0);
`endif
    endtask

    // One clock cycle, entered and left at a falling edge; returns whether the model accepted the push.
    task automatic cycle(input logic v, input logic [63:0] d, input logic r, output bit accepted);
        bit          push_m;
        bit          pop_m;
        logic [63:0] head;
        logic [63:0] popped;
        up_vld  = v;
        up_data = v ? d : {$urandom, $urandom};
        dn_rdy  = r;
        #1;
        check_state();
        head   = dn_data;
        push_m = v && (exp_q.size() < DEPTH);
        pop_m  = r && (exp_q.size() != 0);
        @(posedge clk);
        if (pop_m) begin
            popped = exp_q.pop_front();
            out_q.push_back(head);
            pops++;
            tot_m++;
            if (is_special(popped)) spec_m++;
        end
        if (push_m) begin
            exp_q.push_back(d);
            pushes++;
        end
        accepted = push_m;
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        bit acc;
        for (int i = 0; i < 4 * DEPTH && exp_q.size() != 0; i++) cycle(1'b0, 64'd0, 1'b1, acc);
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        out_q.delete();
        tot_m  = 0;
        spec_m = 0;
    endtask

    initial begin
        bit          acc;
        int          idx;
        logic [63:0] vals[$];
        logic [63:0] sent[$];

        // Reset held for three cycles.
        rst = 1'b0; up_vld = 1'b0; dn_rdy = 1'b0; up_data = '0;
        repeat (3) @(negedge clk);
        check_state();
        rst = 1'b1;

        // Single push held for five cycles, then one pop.
        cycle(1'b1, 64'h4000_0000_0000_0000, 1'b0, acc);
        check("single_count", 64'(count), 64'd1);
        check("single_data", dn_data, 64'h4000_0000_0000_0000);
        repeat (5) cycle(1'b0, 64'd0, 1'b0, acc);
        cycle(1'b0, 64'd0, 1'b1, acc);
        check("single_empty_vld", 64'(dn_vld), 64'd0);
        check("single_empty_cnt", 64'(count), 64'd0);

        // Fill past capacity with 1..10, then drain while offering the rest.
        out_q.delete();
        idx = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(idx < 10, 64'(idx + 1), 1'b0, acc);
            if (acc) idx++;
        end
        check("fill_count", 64'(count), 64'(DEPTH));
        check("fill_up_rdy", 64'(up_rdy), 64'd0);
        check("fill_accepted", 64'(idx), 64'(DEPTH));
        for (int i = 0; i < 30 && (idx < 10 || exp_q.size() != 0); i++) begin
            cycle(idx < 10, 64'(idx + 1), 1'b1, acc);
            if (acc) idx++;
        end
        check("fill_out_len", 64'(out_q.size()), 64'd10);
        for (int i = 0; i < out_q.size(); i++) check("fill_order", out_q[i], 64'(i + 1));

        // Simultaneous push and pop at occupancy 3.
        vals = '{64'hA1, 64'hA2, 64'hA3};
        foreach (vals[i]) cycle(1'b1, vals[i], 1'b0, acc);
        cycle(1'b1, 64'hA4, 1'b1, acc);
        check("pushpop_count", 64'(count), 64'd3);
        check("pushpop_head", dn_data, 64'hA2);
        drain("pushpop_drain");

        // 100 back-to-back results with the consumer always ready.
        out_q.delete();
        sent.delete();
        for (int i = 0; i < 100; i++) begin
            sent.push_back(rand_val());
            cycle(1'b1, sent[i], 1'b1, acc);
            check("stream_accept", 64'(acc), 64'd1);
            check("stream_count_le1", 64'(count <= CW'(1)), 64'd1);
        end
        drain("stream_drain");
        check("stream_len", 64'(out_q.size()), 64'd100);
        for (int i = 0; i < out_q.size() && i < 100; i++) check("stream_order", out_q[i], sent[i]);

        // Random valid/ready traffic: order and no loss.
        out_q.delete();
        sent.delete();
        for (int i = 0; i < 300; i++) begin
            logic [63:0] v;
            v = rand_val();
            cycle(1'($urandom_range(0, 1)), v, 1'($urandom_range(0, 1)), acc);
            if (acc) sent.push_back(v);
        end
        drain("random_drain");
        check("random_len", 64'(out_q.size()), 64'(sent.size()));
        for (int i = 0; i < out_q.size() && i < sent.size(); i++) check("random_order", out_q[i], sent[i]);
        check("random_balance", 64'(pushes), 64'(pops));

        // Asynchronous reset with five entries queued.
        for (int i = 0; i < 5; i++) cycle(1'b1, rand_val(), 1'b0, acc);
        check("pre_reset_count", 64'(count), 64'd5);
        #2 rst = 1'b0;
        #1;
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_vld", 64'(dn_vld), 64'd0);
        check("async_rst_rdy", 64'(up_rdy), 64'd1);
        model_reset();
        @(negedge clk);
        check_state();
        rst = 1'b1;

        // Statistics over one NaN, one -Inf and one ordinary value.
        vals = '{64'h7FF8_0000_0000_0000, 64'hFFF0_0000_0000_0000, 64'h3FF0_0000_0000_0000};
        foreach (vals[i]) cycle(1'b1, vals[i], 1'b0, acc);
        drain("stats_drain");
`ifdef FP_RESULT_FIFO_STATS_EN
        check("stats_total", 64'(stat_total), 64'd3);
        check("stats_special", 64'(stat_special), 64'd2);
`else
        check("stats_total", 64'(stat_total), 64'd0);
        check("stats_special", 64'(stat_special), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
